wb_multi: RTL and testbench
===========================

WB_MULTI -- requirements
Module: wb_multi

Interface
REQ-001 The block SHALL take parameter NCH, default 2 (range 1..4): number of writeback lanes per bundle; lane 0 is the oldest.
REQ-002 The block SHALL take parameter XLEN, default 32: data and PC width.
REQ-003 The block SHALL take parameter FLUSH_CYC, default 2 (range 1..15): length of the discard window after a redirect.
REQ-004 The block SHALL take parameter CNT_W, default 32: retired-instruction counter width.
REQ-005 Ports SHALL be exactly as follows, one per line (name direction width meaning):
 clk  in  1  single clock, all state on rising edge
 resetn  in  1  reset, synchronous, active-low
 in_valid  in  1  bundle offered
 in_ready  out  1  bundle accepted when in_valid & in_ready
 in_lane_vld  in  NCH  lane holds a real instruction
 in_wen  in  NCH  lane writes the GPR file
 in_wdest  in  NCH*5  destination register per lane
 in_wdata  in  NCH*XLEN  result per lane
 in_hi_we, in_lo_we  in  NCH each  HI/LO write per lane
 in_hi, in_lo  in  NCH*XLEN each  HI/LO write data
 in_mfhi, in_mflo  in  NCH each  lane result is HI/LO
 in_exc  in  NCH  lane raised a synchronous exception
 in_exc_code  in  NCH*5  ExcCode per lane
 in_eret  in  NCH  lane is ERET
 in_pc  in  NCH*XLEN  PC per lane
 int_req  in  1  pending interrupt from CP0
 rf_wen  out  NCH  registered GPR write enable
 rf_wdest  out  NCH*5  registered destination
 rf_wdata  out  NCH*XLEN  registered write data
 exc_valid  out  1  one-cycle exception report to CP0
 exc_code  out  5  ExcCode (0 = interrupt)
 exc_pc  out  XLEN  PC of the faulting lane
 eret_out  out  1  one-cycle ERET report
 cancel  out  1  one-cycle pipeline flush
 hi_data, lo_data  out  XLEN each  architectural HI/LO
 retire_cnt  out  CNT_W  committed-instruction count

Function
REQ-006 The FSM SHALL have two states: RUN and FLUSH.
REQ-007 In RUN, in_ready SHALL be 1.
REQ-008 In FLUSH, in_ready SHALL also be 1, and every accepted bundle SHALL be discarded (no GPR, HI/LO, counter or exception effect).
REQ-009 The boundary lane B SHALL be the lowest lane with in_lane_vld & (in_exc | in_eret); B = NCH if there is none.
REQ-010 If int_req=1 at acceptance in RUN, B SHALL be 0, the reported code SHALL be 0, and interrupt SHALL take priority over any lane exception.
REQ-011 Lanes below B with in_lane_vld SHALL commit; lanes at or above B SHALL NOT commit.
REQ-012 An ERET at lane B SHALL itself count as committed; an excepting lane SHALL NOT.
REQ-013 The committed-lane write enable SHALL be in_wen & (in_wdest != 0).
REQ-014 Within a bundle, if two committed lanes write the same nonzero wdest, the older lane's rf_wen SHALL be suppressed.
REQ-015 The rf_* outputs SHALL be registered: a bundle accepted at edge N SHALL drive its rf_* values during cycle N+1 only.
REQ-016 If no bundle is accepted, rf_wen SHALL be 0 on the next cycle.
REQ-017 For a committed lane j, the result SHALL be selected as: in_mfhi gives HI as seen by lane j; in_mflo gives LO as seen by lane j; otherwise in_wdata.
REQ-018 "HI as seen by lane j" SHALL be in_hi of the youngest committed lane k<j with in_hi_we, else the HI register; LO SHALL follow the same rule.
REQ-019 HI/LO registers SHALL update at the acceptance edge from the youngest committed lane writing them.
REQ-020 On an accepted bundle with B<NCH in RUN, the block SHALL register the following for exactly one cycle (N+1): exc_valid=1 (exception or interrupt) or eret_out=1 (ERET), plus exc_code, exc_pc=in_pc[B], and cancel=1.
REQ-021 After a redirect bundle, the state SHALL move to FLUSH for FLUSH_CYC cycles (down-counter), then return to RUN.
REQ-022 retire_cnt SHALL add the number of committed lanes (0..NCH) per accepted bundle and SHALL wrap modulo 2^CNT_W.
REQ-023 exc_valid, eret_out and cancel SHALL be 0 in every cycle not covered by REQ-020.
REQ-024 int_req arriving in FLUSH or with no bundle accepted SHALL be ignored; it is re-evaluated at the next accepted RUN bundle.

Reset
REQ-025 When resetn=0 at a clock edge, the block SHALL set state RUN, clear the flush counter, and zero every registered output, HI, LO and retire_cnt.
REQ-026 Reset SHALL override an accepted bundle or FLUSH in the same cycle, and no partial commit SHALL be visible afterwards.

Verification
REQ-027 NCH=2: lane0 writes r3=5, lane1 writes r4=7 -> next cycle rf_wen=2'b11 with data 5 and 7; retire_cnt +2.
REQ-028 lane0 in_hi_we with in_hi=0xA, lane1 mfhi -> lane1 rf_wdata=0xA; hi_data=0xA the following cycle.
REQ-029 lane0 commits r5, lane1 in_exc code 4 -> rf_wen=2'b01, exc_valid=1, exc_code=4, exc_pc=pc1, cancel=1 for one cycle; the next FLUSH_CYC bundles are discarded.
REQ-030 int_req=1 with lane0 ERET -> no commit, exc_code=0, eret_out=0, retire_cnt unchanged.
REQ-031 Both lanes write r9 (values 1 and 2) -> only lane1 rf_wen=1, with data 2.
REQ-032 resetn=0 asserted during FLUSH -> next cycle state RUN, all outputs 0, in_ready=1.

Source files
------------

// File: rtl/wb_multi.sv
// Multi-lane writeback stage: commits the in-order prefix of each bundle up to
// the first exception/ERET (or a pending interrupt), forwards HI/LO inside the
// bundle, reports redirects to CP0 and discards bundles for a short window
// after a redirect.
module wb_multi #(
  parameter int NCH       = 2,
  parameter int XLEN      = 32,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH-1:0]        in_lane_vld,
  input  logic [NCH-1:0]        in_wen,
  input  logic [NCH*5-1:0]      in_wdest,
  input  logic [NCH*XLEN-1:0]   in_wdata,
  input  logic [NCH-1:0]        in_hi_we,
  input  logic [NCH-1:0]        in_lo_we,
  input  logic [NCH*XLEN-1:0]   in_hi,
  input  logic [NCH*XLEN-1:0]   in_lo,
  input  logic [NCH-1:0]        in_mfhi,
  input  logic [NCH-1:0]        in_mflo,
  input  logic [NCH-1:0]        in_exc,
  input  logic [NCH*5-1:0]      in_exc_code,
  input  logic [NCH-1:0]        in_eret,
  input  logic [NCH*XLEN-1:0]   in_pc,
  input  logic                  int_req,
  output logic [NCH-1:0]        rf_wen,
  output logic [NCH*5-1:0]      rf_wdest,
  output logic [NCH*XLEN-1:0]   rf_wdata,
  output logic                  exc_valid,
  output logic [4:0]            exc_code,
  output logic [XLEN-1:0]       exc_pc,
  output logic                  eret_out,
  output logic                  cancel,
  output logic [XLEN-1:0]       hi_data,
  output logic [XLEN-1:0]       lo_data,
  output logic [CNT_W-1:0]      retire_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [3:0]            fcnt_q, fcnt_d;
  logic [NCH-1:0]        rf_wen_q, rf_wen_d;
  logic [NCH*5-1:0]      rf_wdest_q, rf_wdest_d;
  logic [NCH*XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic                  exc_valid_q, exc_valid_d;
  logic [4:0]            exc_code_q, exc_code_d;
  logic [XLEN-1:0]       exc_pc_q, exc_pc_d;
  logic                  eret_q, eret_d;
  logic                  cancel_q, cancel_d;
  logic [XLEN-1:0]       hi_q, hi_d;
  logic [XLEN-1:0]       lo_q, lo_d;
  logic [CNT_W-1:0]      rcnt_q, rcnt_d;

  logic                  acc_run;
  logic                  blk;
  logic                  bnd_eret;
  logic [4:0]            bnd_code;
  logic [XLEN-1:0]       bnd_pc;
  logic [NCH-1:0]        commit;
  logic [NCH-1:0]        we;
  logic [XLEN-1:0]       hi_run, lo_run;
  logic [CNT_W-1:0]      ncommit;

  assign in_ready = 1'b1;
  assign acc_run  = in_valid && (state_q == RUN);

  // Lane walk, oldest first: find the boundary, decide commits, and forward
  // HI/LO so each lane sees only writes from older committed lanes.
  always_comb begin
    blk        = acc_run && int_req;
    bnd_eret   = 1'b0;
    bnd_code   = '0;
    bnd_pc     = in_pc[0 +: XLEN];
    commit     = '0;
    we         = '0;
    hi_run     = hi_q;
    lo_run     = lo_q;
    ncommit    = '0;
    rf_wdata_d = '0;
    for (int unsigned j = 0; j < NCH; j++) begin
      if (acc_run && !blk && in_lane_vld[j]) begin
        if (in_exc[j] || in_eret[j]) begin
          blk       = 1'b1;
          bnd_eret  = !in_exc[j];
          bnd_code  = in_exc_code[j*5 +: 5];
          bnd_pc    = in_pc[j*XLEN +: XLEN];
          commit[j] = !in_exc[j];
        end else begin
          commit[j] = 1'b1;
        end
      end
      if (in_mfhi[j])
        rf_wdata_d[j*XLEN +: XLEN] = hi_run;
      else if (in_mflo[j])
        rf_wdata_d[j*XLEN +: XLEN] = lo_run;
      else
        rf_wdata_d[j*XLEN +: XLEN] = in_wdata[j*XLEN +: XLEN];
      if (commit[j]) begin
        we[j]   = in_wen[j] && (in_wdest[j*5 +: 5] != 5'd0);
        ncommit = ncommit + CNT_W'(1);
        if (in_hi_we[j]) hi_run = in_hi[j*XLEN +: XLEN];
        if (in_lo_we[j]) lo_run = in_lo[j*XLEN +: XLEN];
      end
    end
    hi_d   = hi_run;
    lo_d   = lo_run;
    rcnt_d = rcnt_q + ncommit;
  end

  // Same-destination writes within a bundle: only the youngest lane writes.
  always_comb begin
    rf_wen_d   = we;
    rf_wdest_d = in_wdest;
    for (int unsigned j = 0; j < NCH; j++) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (k > j && we[k] && (in_wdest[k*5 +: 5] == in_wdest[j*5 +: 5]))
          rf_wen_d[j] = 1'b0;
      end
    end
  end

  // RUN/FLUSH control and one-cycle redirect reports.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    exc_valid_d = 1'b0;
    eret_d      = 1'b0;
    cancel_d    = 1'b0;
    exc_code_d  = '0;
    exc_pc_d    = '0;
    case (state_q)
      RUN: begin
        if (blk) begin
          state_d     = FLUSH;
          fcnt_d      = 4'(FLUSH_CYC);
          exc_valid_d = !bnd_eret;
          eret_d      = bnd_eret;
          cancel_d    = 1'b1;
          exc_code_d  = bnd_code;
          exc_pc_d    = bnd_pc;
        end
      end
      FLUSH: begin
        if (fcnt_q <= 4'd1) begin
          state_d = RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    endcase
  end

  // State and registered outputs; reset discards any same-cycle bundle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      rf_wen_q    <= '0;
      rf_wdest_q  <= '0;
      rf_wdata_q  <= '0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= '0;
      exc_pc_q    <= '0;
      eret_q      <= 1'b0;
      cancel_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      rcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      rf_wen_q    <= rf_wen_d;
      rf_wdest_q  <= rf_wdest_d;
      rf_wdata_q  <= rf_wdata_d;
      exc_valid_q <= exc_valid_d;
      exc_code_q  <= exc_code_d;
      exc_pc_q    <= exc_pc_d;
      eret_q      <= eret_d;
      cancel_q    <= cancel_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      rcnt_q      <= rcnt_d;
    end
  end

  assign rf_wen     = rf_wen_q;
  assign rf_wdest   = rf_wdest_q;
  assign rf_wdata   = rf_wdata_q;
  assign exc_valid  = exc_valid_q;
  assign exc_code   = exc_code_q;
  assign exc_pc     = exc_pc_q;
  assign eret_out   = eret_q;
  assign cancel     = cancel_q;
  assign hi_data    = hi_q;
  assign lo_data    = lo_q;
  assign retire_cnt = rcnt_q;

endmodule

// File: tb/tb_wb_multi.sv
// Directed-vector bench for wb_multi (NCH=2, FLUSH_CYC=2): each vector carries
// its hand-computed expected outputs, which the driver queues after the
// acceptance edge and a monitor compares on the following falling edge.
module tb_wb_multi;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_lane_vld, in_wen, in_hi_we, in_lo_we, in_mfhi, in_mflo, in_exc, in_eret;
  logic [9:0]  in_wdest, in_exc_code;
  logic [63:0] in_wdata, in_hi, in_lo, in_pc;
  logic        int_req;
  logic [1:0]  rf_wen;
  logic [9:0]  rf_wdest;
  logic [63:0] rf_wdata;
  logic        exc_valid, eret_out, cancel;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, hi_data, lo_data, retire_cnt;

  always #5 clk = ~clk;

  wb_multi #(.NCH(2), .XLEN(32), .FLUSH_CYC(2), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(in_lane_vld), .in_wen(in_wen), .in_wdest(in_wdest),
    .in_wdata(in_wdata), .in_hi_we(in_hi_we), .in_lo_we(in_lo_we),
    .in_hi(in_hi), .in_lo(in_lo), .in_mfhi(in_mfhi), .in_mflo(in_mflo),
    .in_exc(in_exc), .in_exc_code(in_exc_code), .in_eret(in_eret),
    .in_pc(in_pc), .int_req(int_req), .rf_wen(rf_wen), .rf_wdest(rf_wdest),
    .rf_wdata(rf_wdata), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .eret_out(eret_out), .cancel(cancel),
    .hi_data(hi_data), .lo_data(lo_data), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic rstn, valid, intr;
    logic [1:0] lvld, wen, hiwe, lowe, mfhi, mflo, exc, eret;
    logic [9:0] wdest, code;
    logic [63:0] wdata, hi, lo, pc;
  } stim_t;

  typedef struct {
    logic all;
    logic [1:0] wen;
    logic [9:0] wdest;
    logic [63:0] wdata;
    logic exc_v, eret, cancel;
    logic [4:0] code;
    logic [31:0] epc, hi, lo, rcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rstn = 1'b1; s.valid = 1'b0; s.intr = 1'b0;
    s.lvld = '0; s.wen = '0; s.hiwe = '0; s.lowe = '0;
    s.mfhi = '0; s.mflo = '0; s.exc = '0; s.eret = '0;
    s.wdest = '0; s.code = '0; s.wdata = '0; s.hi = '0; s.lo = '0; s.pc = '0;
    return s;
  endfunction

  function automatic exp_t ex(logic [1:0] wen, logic [31:0] hi, logic [31:0] lo, logic [31:0] rcnt);
    exp_t e;
    e.all = 1'b0; e.wen = wen; e.wdest = '0; e.wdata = '0;
    e.exc_v = 1'b0; e.eret = 1'b0; e.cancel = 1'b0; e.code = '0; e.epc = '0;
    e.hi = hi; e.lo = lo; e.rcnt = rcnt;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus, then queue what the next cycle must show.
  task automatic apply(input stim_t s, input exp_t e);
    resetn = s.rstn; in_valid = s.valid; int_req = s.intr;
    in_lane_vld = s.lvld; in_wen = s.wen; in_hi_we = s.hiwe; in_lo_we = s.lowe;
    in_mfhi = s.mfhi; in_mflo = s.mflo; in_exc = s.exc; in_eret = s.eret;
    in_wdest = s.wdest; in_exc_code = s.code; in_wdata = s.wdata;
    in_hi = s.hi; in_lo = s.lo; in_pc = s.pc;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: every queued expectation is checked against the registered outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("in_ready", 64'(in_ready), 64'd1);
      chk("rf_wen", 64'(rf_wen), 64'(e.wen));
      for (int l = 0; l < 2; l++) begin
        if (e.all || e.wen[l]) begin
          chk($sformatf("rf_wdest[%0d]", l), 64'(rf_wdest[l*5 +: 5]), 64'(e.wdest[l*5 +: 5]));
          chk($sformatf("rf_wdata[%0d]", l), 64'(rf_wdata[l*32 +: 32]), 64'(e.wdata[l*32 +: 32]));
        end
      end
      chk("exc_valid", 64'(exc_valid), 64'(e.exc_v));
      chk("eret_out", 64'(eret_out), 64'(e.eret));
      chk("cancel", 64'(cancel), 64'(e.cancel));
      if (e.all || e.exc_v) chk("exc_code", 64'(exc_code), 64'(e.code));
      if (e.all || e.exc_v || e.eret) chk("exc_pc", 64'(exc_pc), 64'(e.epc));
      chk("hi_data", 64'(hi_data), 64'(e.hi));
      chk("lo_data", 64'(lo_data), 64'(e.lo));
      chk("retire_cnt", 64'(retire_cnt), 64'(e.rcnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    exp_t  e, z;
    z = ex(2'b00, 0, 0, 0);
    z.all = 1'b1;

    // Reset state
    s = idle(); s.rstn = 1'b0;
    apply(s, z);
    apply(s, z);

    // Two independent writes r3=5, r4=7
    s = idle(); s.valid = 1; s.lvld = 2'b11; s.wen = 2'b11;
    s.wdest = {5'd4, 5'd3}; s.wdata = {32'd7, 32'd5};
    e = ex(2'b11, 0, 0, 2); e.wdest = {5'd4, 5'd3}; e.wdata = {32'd7, 32'd5};
    apply(s, e);

    // lane0 writes HI=0xA, lane1 mfhi into r6 sees it
    s = idle(); s.valid = 1; s.lvld = 2'b11; s.hiwe = 2'b01; s.hi = {32'h0, 32'hA};
    s.mfhi = 2'b10; s.wen = 2'b10; s.wdest = {5'd6, 5'd0}; s.wdata = {32'h99, 32'h0};
    e = ex(2'b10, 32'hA, 0, 4); e.wdest = {5'd6, 5'd0}; e.wdata = {32'hA, 32'h0};
    apply(s, e);

    // No bundle: write enables drop, HI holds
    apply(idle(), ex(2'b00, 32'hA, 0, 4));

    // lane0 mflo sees old LO (0); younger lane1 writes LO=0x55
    s = idle(); s.valid = 1; s.lvld = 2'b11; s.mflo = 2'b01; s.wen = 2'b01;
    s.wdest = {5'd0, 5'd7}; s.wdata = {32'h0, 32'h123}; s.lowe = 2'b10; s.lo = {32'h55, 32'h0};
    e = ex(2'b01, 32'hA, 32'h55, 6); e.wdest = {5'd0, 5'd7}; e.wdata = {32'h0, 32'h0};
    apply(s, e);

    // lane0 mflo now reads LO register 0x55; lane1 not valid
    s = idle(); s.valid = 1; s.lvld = 2'b01; s.mflo = 2'b01; s.wen = 2'b11;
    s.wdest = {5'd20, 5'd8}; s.wdata = {32'h1, 32'h2};
    e = ex(2'b01, 32'hA, 32'h55, 7); e.wdest = {5'd0, 5'd8}; e.wdata = {32'h0, 32'h55};
    apply(s, e);

    // Both lanes write r9: only the younger lane writes
    s = idle(); s.valid = 1; s.lvld = 2'b11; s.wen = 2'b11;
    s.wdest = {5'd9, 5'd9}; s.wdata = {32'd2, 32'd1};
    e = ex(2'b10, 32'hA, 32'h55, 9); e.wdest = {5'd9, 5'd0}; e.wdata = {32'd2, 32'd0};
    apply(s, e);

    // Write to r0 is suppressed but still retires
    s = idle(); s.valid = 1; s.lvld = 2'b11; s.wen = 2'b11;
    s.wdest = {5'd1, 5'd0}; s.wdata = {32'd3, 32'd4};
    e = ex(2'b10, 32'hA, 32'h55, 11); e.wdest = {5'd1, 5'd0}; e.wdata = {32'd3, 32'd0};
    apply(s, e);

    // lane0 commits r5, lane1 exception code 4
    s = idle(); s.valid = 1; s.lvld = 2'b11; s.wen = 2'b11; s.exc = 2'b10;
    s.wdest = {5'd6, 5'd5}; s.wdata = {32'hEE, 32'h11}; s.code = {5'd4, 5'd0};
    s.pc = {32'h1004, 32'h1000};
    e = ex(2'b01, 32'hA, 32'h55, 12); e.wdest = {5'd0, 5'd5}; e.wdata = {32'h0, 32'h11};
    e.exc_v = 1; e.code = 5'd4; e.epc = 32'h1004; e.cancel = 1;
    apply(s, e);

    // Two discarded bundles (writes, HI write and interrupt all ignored)
    s = idle(); s.valid = 1; s.lvld = 2'b11; s.wen = 2'b11; s.intr = 1;
    s.wdest = {5'd10, 5'd10}; s.wdata = {32'h5, 32'h6}; s.hiwe = 2'b01; s.hi = {32'h0, 32'hBAD};
    apply(s, ex(2'b00, 32'hA, 32'h55, 12));
    apply(s, ex(2'b00, 32'hA, 32'h55, 12));

    // Back in RUN: commits again
    s = idle(); s.valid = 1; s.lvld = 2'b01; s.wen = 2'b01;
    s.wdest = {5'd0, 5'd11}; s.wdata = {32'h0, 32'h33};
    e = ex(2'b01, 32'hA, 32'h55, 13); e.wdest = {5'd0, 5'd11}; e.wdata = {32'h0, 32'h33};
    apply(s, e);

    // Interrupt beats lane0 ERET: no commit, code 0, pc of lane 0
    s = idle(); s.valid = 1; s.intr = 1; s.lvld = 2'b11; s.eret = 2'b01; s.wen = 2'b10;
    s.wdest = {5'd12, 5'd0}; s.wdata = {32'h9, 32'h0}; s.pc = {32'h2004, 32'h2000};
    s.code = {5'd0, 5'd3};
    e = ex(2'b00, 32'hA, 32'h55, 13); e.exc_v = 1; e.code = 5'd0; e.epc = 32'h2000; e.cancel = 1;
    apply(s, e);
    apply(idle(), ex(2'b00, 32'hA, 32'h55, 13));
    apply(idle(), ex(2'b00, 32'hA, 32'h55, 13));

    // ERET at lane1: retires along with lane0
    s = idle(); s.valid = 1; s.lvld = 2'b11; s.wen = 2'b01; s.eret = 2'b10;
    s.wdest = {5'd0, 5'd13}; s.wdata = {32'h0, 32'h44}; s.pc = {32'h3004, 32'h3000};
    e = ex(2'b01, 32'hA, 32'h55, 15); e.wdest = {5'd0, 5'd13}; e.wdata = {32'h0, 32'h44};
    e.eret = 1; e.epc = 32'h3004; e.cancel = 1;
    apply(s, e);
    apply(idle(), ex(2'b00, 32'hA, 32'h55, 15));
    apply(idle(), ex(2'b00, 32'hA, 32'h55, 15));

    // Exception flag on an invalid lane is ignored
    s = idle(); s.valid = 1; s.lvld = 2'b10; s.exc = 2'b01; s.wen = 2'b10;
    s.wdest = {5'd14, 5'd0}; s.wdata = {32'h77, 32'h0};
    e = ex(2'b10, 32'hA, 32'h55, 16); e.wdest = {5'd14, 5'd0}; e.wdata = {32'h77, 32'h0};
    apply(s, e);

    // Interrupt with no bundle accepted is ignored
    s = idle(); s.intr = 1;
    apply(s, ex(2'b00, 32'hA, 32'h55, 16));

    // Redirect, then reset during FLUSH with a bundle offered
    s = idle(); s.valid = 1; s.lvld = 2'b01; s.exc = 2'b01; s.code = {5'd0, 5'd8};
    s.pc = {32'h0, 32'h4000};
    e = ex(2'b00, 32'hA, 32'h55, 16); e.exc_v = 1; e.code = 5'd8; e.epc = 32'h4000; e.cancel = 1;
    apply(s, e);
    s = idle(); s.rstn = 0; s.valid = 1; s.lvld = 2'b11; s.wen = 2'b11; s.exc = 2'b10;
    s.wdest = {5'd21, 5'd20}; s.wdata = {32'h1, 32'h2}; s.hiwe = 2'b01; s.hi = {32'h0, 32'h7};
    apply(s, z);

    // Immediately back in RUN after reset
    s = idle(); s.valid = 1; s.lvld = 2'b01; s.wen = 2'b01;
    s.wdest = {5'd0, 5'd15}; s.wdata = {32'h0, 32'h5};
    e = ex(2'b01, 0, 0, 1); e.wdest = {5'd0, 5'd15}; e.wdata = {32'h0, 32'h5};
    apply(s, e);
    apply(idle(), ex(2'b00, 0, 0, 1));

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
